// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, sync, data enable,
// line/frame strobes and a frame counter, advanced by a pixel clock-enable.
module video_timing_gen #(
   parameter int CORDW    = 10,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int FCW      = 16
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   input  logic             ce,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line,
   output logic             frame,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);

   // One extra bit so a boundary equal to 2^CORDW still compares correctly.
   localparam logic [CORDW:0] H_ACT_E  = (CORDW+1)'(H_ACTIVE);
   localparam logic [CORDW:0] HS_BEG   = (CORDW+1)'(H_ACTIVE + H_FP);
   localparam logic [CORDW:0] HS_END   = (CORDW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CORDW:0] V_ACT_E  = (CORDW+1)'(V_ACTIVE);
   localparam logic [CORDW:0] VS_BEG   = (CORDW+1)'(V_ACTIVE + V_FP);
   localparam logic [CORDW:0] VS_END   = (CORDW+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic HP = 1'(H_POL);
   localparam logic VP = 1'(V_POL);

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_bad_params
      $error("video_timing_gen: illegal timing parameters");
   end

   logic [CORDW-1:0] r_sx;
   logic [CORDW-1:0] r_sy;
   logic             r_hs;
   logic             r_vs;
   logic             r_de;
   logic             r_line;
   logic             r_frame;
   logic [FCW-1:0]   r_fc;

   logic [CORDW-1:0] w_sx_nxt;
   logic [CORDW-1:0] w_sy_nxt;
   logic             w_hs_act;
   logic             w_vs_act;
   logic             w_de_nxt;
   logic             w_line_nxt;
   logic             w_frame_nxt;

   always_comb begin
      w_sx_nxt = r_sx;
      w_sy_nxt = r_sy;
      if (ce) begin
         if (r_sx == H_LAST) begin
            w_sx_nxt = '0;
            w_sy_nxt = (r_sy == V_LAST) ? '0 : r_sy + 1'b1;
         end else begin
            w_sx_nxt = r_sx + 1'b1;
         end
      end
   end

   // Decode on the next coordinates so sync/de line up with sx/sy.
   always_comb begin
      w_de_nxt    = ({1'b0, w_sx_nxt} < H_ACT_E) && ({1'b0, w_sy_nxt} < V_ACT_E);
      w_hs_act    = ({1'b0, w_sx_nxt} >= HS_BEG) && ({1'b0, w_sx_nxt} < HS_END);
      w_vs_act    = ({1'b0, w_sy_nxt} >= VS_BEG) && ({1'b0, w_sy_nxt} < VS_END);
      w_line_nxt  = ce && (w_sx_nxt == '0);
      w_frame_nxt = w_line_nxt && (w_sy_nxt == '0);
   end

   // Reset parks the raster on its last pixel so the first ce lands on (0,0).
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         r_sx    <= H_LAST;
         r_sy    <= V_LAST;
         r_hs    <= ~HP;
         r_vs    <= ~VP;
         r_de    <= 1'b0;
         r_line  <= 1'b0;
         r_frame <= 1'b0;
         r_fc    <= '1;
      end else if (ce) begin
         r_sx    <= w_sx_nxt;
         r_sy    <= w_sy_nxt;
         r_hs    <= ~(w_hs_act ^ HP);
         r_vs    <= ~(w_vs_act ^ VP);
         r_de    <= w_de_nxt;
         r_line  <= w_line_nxt;
         r_frame <= w_frame_nxt;
         if (w_frame_nxt) begin
            r_fc <= r_fc + 1'b1;
         end
      end else begin
         r_line  <= 1'b0;
         r_frame <= 1'b0;
      end
   end

   assign sx        = r_sx;
   assign sy        = r_sy;
   assign hsync     = r_hs;
   assign vsync     = r_vs;
   assign de        = r_de;
   assign line      = r_line;
   assign frame     = r_frame;
   assign frame_cnt = r_fc;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small active-low mode (FCW=2), small active-high
// mode and the default 640x480 mode, all sharing clock, ce and reset.
module tb_video_timing_gen;

   localparam int W = 85;

   logic clk;
   logic rst_n;
   logic ce;

   logic [3:0]  a_sx, a_sy;
   logic        a_hs, a_vs, a_de, a_line, a_frame;
   logic [1:0]  a_fc;
   logic [3:0]  b_sx, b_sy;
   logic        b_hs, b_vs, b_de, b_line, b_frame;
   logic [15:0] b_fc;
   logic [9:0]  c_sx, c_sy;
   logic        c_hs, c_vs, c_de, c_line, c_frame;
   logic [15:0] c_fc;

   video_timing_gen #(
      .CORDW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(0), .V_POL(0), .FCW(2)
   ) u_a (
      .clk_pix(clk), .rst_pix_n(rst_n), .ce(ce),
      .sx(a_sx), .sy(a_sy), .hsync(a_hs), .vsync(a_vs), .de(a_de),
      .line(a_line), .frame(a_frame), .frame_cnt(a_fc)
   );

   video_timing_gen #(
      .CORDW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1), .V_POL(1), .FCW(16)
   ) u_b (
      .clk_pix(clk), .rst_pix_n(rst_n), .ce(ce),
      .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs), .de(b_de),
      .line(b_line), .frame(b_frame), .frame_cnt(b_fc)
   );

   video_timing_gen u_c (
      .clk_pix(clk), .rst_pix_n(rst_n), .ce(ce),
      .sx(c_sx), .sy(c_sy), .hsync(c_hs), .vsync(c_vs), .de(c_de),
      .line(c_line), .frame(c_frame), .frame_cnt(c_fc)
   );

   logic [W-1:0] obs;
   assign obs = {a_sx, a_sy, a_hs, a_vs, a_de, a_line, a_frame, a_fc,
                 b_sx, b_sy, b_hs, b_vs, b_de, b_line, b_frame, b_fc,
                 c_sx, c_sy, c_hs, c_vs, c_de, c_line, c_frame, c_fc};

   logic [W-1:0] exp_q[$];
   int    n_err    = 0;
   int    n_checks = 0;
   int    cyc      = 0;
   int    k        = 0;  // ce edges since reset release
   string phase    = "reset";

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_checks);
      $fatal(1, "watchdog");
   end

   // Expected outputs from the ce-edge index alone (k==0: still at reset values).
   function automatic logic [W-1:0] model(input int kk, input bit cev);
      logic [3:0]  asx, asy;
      logic        ahs, avs, ade, aln, afr;
      logic [1:0]  afc;
      logic [15:0] bfc;
      logic [9:0]  csx, csy;
      logic        chs, cvs, cde, cln, cfr;
      logic [15:0] cfc;
      int p;
      if (kk == 0) begin
         asx = 4'd13; asy = 4'd7; ahs = 1'b1; avs = 1'b1;
         ade = 1'b0; aln = 1'b0; afr = 1'b0; afc = 2'b11; bfc = 16'hffff;
         csx = 10'd799; csy = 10'd524; chs = 1'b1; cvs = 1'b1;
         cde = 1'b0; cln = 1'b0; cfr = 1'b0; cfc = 16'hffff;
      end else begin
         p   = kk - 1;
         asx = 4'(p % 14);
         asy = 4'((p / 14) % 8);
         ade = (asx < 4'd8) && (asy < 4'd4);
         ahs = !((asx >= 4'd10) && (asx < 4'd13));
         avs = !((asy >= 4'd5) && (asy < 4'd7));
         aln = cev && (asx == 4'd0);
         afr = aln && (asy == 4'd0);
         afc = 2'((p / 112) % 4);
         bfc = 16'(p / 112);
         csx = 10'(p % 800);
         csy = 10'((p / 800) % 525);
         cde = (csx < 10'd640) && (csy < 10'd480);
         chs = !((csx >= 10'd656) && (csx < 10'd752));
         cvs = !((csy >= 10'd490) && (csy < 10'd492));
         cln = cev && (csx == 10'd0);
         cfr = cln && (csy == 10'd0);
         cfc = 16'(p / 420000);
      end
      return {asx, asy, ahs, avs, ade, aln, afr, afc,
              asx, asy, ~ahs, ~avs, ade, aln, afr, bfc,
              csx, csy, chs, cvs, cde, cln, cfr, cfc};
   endfunction

   // scoreboard
   task automatic compare();
      logic [W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s queue_empty cyc=%0d", phase, cyc);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s cyc=%0d obs=%h exp=%h", phase, cyc, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input int o, input int e);
      n_checks++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
      end
   endtask

   // driver: one clk_pix cycle, expectation queued as the stimulus is applied
   task automatic step(input bit ce_v);
      ce = ce_v;
      if (!rst_n) k = 0;
      else if (ce_v) k++;
      exp_q.push_back(model(k, ce_v && rst_n));
      @(posedge clk);
      #1;
      cyc++;
      compare();
   endtask

   int fc_exp[5];
   int de_cnt, hs_low, fidx, last, lines, periods, line_at;
   bit found;

   initial begin
      fc_exp = '{0, 1, 2, 3, 0};
      rst_n  = 1'b0;
      ce     = 1'b0;
      #1;
      phase = "reset";
      repeat (3) step(1'b0);
      repeat (2) step(1'b1);
      chk("reset_pol_hsync", int'(b_hs), 0);
      chk("reset_pol_vsync", int'(b_vs), 0);
      rst_n = 1'b1;

      phase  = "frames";
      de_cnt = 0;
      fidx   = 0;
      for (int i = 0; i < 560; i++) begin
         step(1'b1);
         if (i == 0) begin
            chk("first_frame", int'(a_frame), 1);
            chk("first_fc", int'(a_fc), 0);
         end
         if (i < 112) de_cnt += int'(a_de);
         if (a_frame) begin
            if (fidx < 5) chk("frame_cnt_seq", int'(a_fc), fc_exp[fidx]);
            fidx++;
         end
      end
      chk("de_per_frame", de_cnt, 32);
      chk("frame_strobes", fidx, 5);

      phase   = "ce_quarter";
      last    = -1;
      lines   = 0;
      periods = 0;
      for (int i = 0; i < 897; i++) begin
         step(i % 4 == 0);
         if (i < 448) lines += int'(a_line);
         if (a_frame) begin
            if (last >= 0) begin
               chk("frame_period", i - last, 448);
               periods++;
            end
            last = i;
         end
      end
      chk("lines_per_frame", lines, 8);
      chk("period_count", periods, 2);

      phase = "midreset";
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step(1'b1);
         if (((k - 1) % 14 == 5) && (((k - 1) / 14) % 8 == 3)) found = 1'b1;
      end
      chk("reach_5_3", int'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      k = 0;
      exp_q.push_back(model(0, 1'b0));
      compare();
      repeat (2) step(1'b1);
      rst_n = 1'b1;

      phase   = "default_mode";
      de_cnt  = 0;
      hs_low  = 0;
      line_at = -1;
      for (int i = 0; i < 1700; i++) begin
         step(1'b1);
         if (i == 0) chk("restart_frame", int'(a_frame), 1);
         if (i < 800) begin
            de_cnt += int'(c_de);
            hs_low += int'(!c_hs);
         end
         if (c_line && i > 0 && line_at < 0) line_at = i;
      end
      chk("c_de_per_line", de_cnt, 640);
      chk("c_hsync_low_per_line", hs_low, 96);
      chk("c_line_period", line_at, 800);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
